// File: rtl/mult_dot_accum.sv
// mult_dot_accum: dot-product accumulator placed after the sequential signed
// multiplier. Each product arriving with the one-cycle done strobe is
// sign-extended and added into an NB_ACC-bit accumulator. After N_TAPS
// products the block total is loaded into o_acc and offered on a
// valid/ready port. A result that is overwritten before the consumer takes
// it raises the sticky o_overrun flag.
//
// Build option: MULT_DOT_ACCUM_SATURATE_EN
//   defined   - sums clamp to the signed NB_ACC range and o_sat reports any
//               clamp that happened within the block on o_acc
//   undefined - sums wrap modulo 2^NB_ACC and o_sat stays 0
//
// Ports:
//   i_clk        clock
//   i_rst        synchronous active-high reset, highest priority
//   i_mult       signed product from the multiplier (NB_DATA bits)
//   i_mult_done  one-cycle strobe, i_mult valid this cycle
//   i_clear      synchronous abort of the partial block; also clears
//                o_valid and o_overrun (o_acc keeps its value)
//   i_ready      consumer takes o_acc this cycle
//   o_acc        signed dot-product result (NB_ACC bits)
//   o_valid      o_acc holds an unconsumed result
//   o_sat        saturation occurred in the block now on o_acc
//   o_overrun    sticky: an unconsumed result was overwritten
//   o_busy       partial block in progress
module mult_dot_accum #(
    parameter int NB_DATA = 4,
    parameter int NB_ACC  = 8,
    parameter int N_TAPS  = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic signed [NB_DATA-1:0] i_mult,
    input  logic                      i_mult_done,
    input  logic                      i_clear,
    input  logic                      i_ready,
    output logic signed [NB_ACC-1:0]  o_acc,
    output logic                      o_valid,
    output logic                      o_sat,
    output logic                      o_overrun,
    output logic                      o_busy
);

    localparam int CNT_W = $clog2(N_TAPS);

`ifdef MULT_DOT_ACCUM_SATURATE_EN
    // One guard bit so overflow of the addition is visible before clamping.
    localparam int SUM_W = NB_ACC + 1;
`else
    // Wrapping keeps only the low NB_ACC bits, which do not depend on the
    // guard bit, so the addition is done directly at NB_ACC bits.
    localparam int SUM_W = NB_ACC;
`endif

    typedef enum logic {
        ACC_IDLE,
        ACC_RUN
    } state_t;

    state_t                    state_q, state_nxt;
    logic        [CNT_W-1:0]   cnt_q, cnt_nxt;
    logic signed [NB_ACC-1:0]  acc_q, acc_nxt;
    logic                      flag_q, flag_nxt;
    logic signed [NB_ACC-1:0]  out_q, out_nxt;
    logic                      valid_q, valid_nxt;
    logic                      sat_q, sat_nxt;
    logic                      ovr_q, ovr_nxt;

    logic signed [NB_ACC-1:0]  ext;
    logic signed [SUM_W-1:0]   sum;
    logic signed [NB_ACC-1:0]  sum_red;
    logic                      clamp;
    logic                      last_tap;

    // Reduce the raw sum to NB_ACC bits; clamp reports whether the value
    // had to be limited.
    function automatic logic signed [NB_ACC-1:0] sat_reduce(
        input  logic signed [SUM_W-1:0] s,
        output logic                    clamped
    );
        logic signed [NB_ACC-1:0] r;
`ifdef MULT_DOT_ACCUM_SATURATE_EN
        // Guard bit disagreeing with the NB_ACC sign bit means out of range;
        // the guard bit gives the true sign of the overflow.
        if (s[SUM_W-1] != s[NB_ACC-1]) begin
            clamped = 1'b1;
            r = s[SUM_W-1] ? {1'b1, {(NB_ACC-1){1'b0}}}
                           : {1'b0, {(NB_ACC-1){1'b1}}};
        end else begin
            clamped = 1'b0;
            r = s[NB_ACC-1:0];
        end
`else
        clamped = 1'b0;
        r = s;
`endif
        return r;
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ACC_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            flag_q  <= 1'b0;
            out_q   <= '0;
            valid_q <= 1'b0;
            sat_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            acc_q   <= acc_nxt;
            flag_q  <= flag_nxt;
            out_q   <= out_nxt;
            valid_q <= valid_nxt;
            sat_q   <= sat_nxt;
            ovr_q   <= ovr_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        acc_nxt   = acc_q;
        flag_nxt  = flag_q;
        out_nxt   = out_q;
        valid_nxt = valid_q;
        sat_nxt   = sat_q;
        ovr_nxt   = ovr_q;
        clamp     = 1'b0;

        ext      = NB_ACC'(i_mult);
        sum      = SUM_W'(acc_q) + SUM_W'(ext);
        sum_red  = sat_reduce(sum, clamp);
        last_tap = (cnt_q == CNT_W'(N_TAPS - 1));

        if (i_clear) begin
            // Abort wins over a coincident strobe; that product is dropped.
            state_nxt = ACC_IDLE;
            cnt_nxt   = '0;
            acc_nxt   = '0;
            flag_nxt  = 1'b0;
            valid_nxt = 1'b0;
            ovr_nxt   = 1'b0;
        end else begin
            if (valid_q && i_ready) begin
                valid_nxt = 1'b0;
            end
            if (i_mult_done) begin
                if (!last_tap) begin
                    state_nxt = ACC_RUN;
                    cnt_nxt   = cnt_q + 1'b1;
                    acc_nxt   = sum_red;
                    flag_nxt  = flag_q | clamp;
                end else begin
                    // A new result overrides a same-cycle consume, so
                    // o_valid stays high and nothing is lost.
                    if (valid_q && !i_ready) begin
                        ovr_nxt = 1'b1;
                    end
                    out_nxt   = sum_red;
                    sat_nxt   = flag_q | clamp;
                    valid_nxt = 1'b1;
                    state_nxt = ACC_IDLE;
                    cnt_nxt   = '0;
                    acc_nxt   = '0;
                    flag_nxt  = 1'b0;
                end
            end
        end
    end

    assign o_acc     = out_q;
    assign o_valid   = valid_q;
    assign o_sat     = sat_q;
    assign o_overrun = ovr_q;
    assign o_busy    = (cnt_q != '0);

endmodule

// File: tb/tb_mult_dot_accum.sv
// Bench for mult_dot_accum: a default-parameter instance driven through a
// cycle model with a result scoreboard, plus a NB_ACC=6 / N_TAPS=8 instance
// for the saturate/wrap boundary.
module tb_mult_dot_accum;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic signed [3:0] mult_a;
    logic              done_a, clear_a, ready_a;
    logic signed [7:0] acc_a;
    logic              valid_a, sat_a, ovr_a, busy_a;

    logic signed [3:0] mult_b;
    logic              done_b, clear_b, ready_b;
    logic signed [5:0] acc_b;
    logic              valid_b, sat_b, ovr_b, busy_b;

    mult_dot_accum #(.NB_DATA(4), .NB_ACC(8), .N_TAPS(4)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_mult(mult_a), .i_mult_done(done_a),
        .i_clear(clear_a), .i_ready(ready_a), .o_acc(acc_a), .o_valid(valid_a),
        .o_sat(sat_a), .o_overrun(ovr_a), .o_busy(busy_a)
    );

    mult_dot_accum #(.NB_DATA(4), .NB_ACC(6), .N_TAPS(8)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_mult(mult_b), .i_mult_done(done_b),
        .i_clear(clear_b), .i_ready(ready_b), .o_acc(acc_b), .o_valid(valid_b),
        .o_sat(sat_b), .o_overrun(ovr_b), .o_busy(busy_b)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int acc;
        bit sat;
    } res_t;
    res_t exp_q[$];

    int m_acc, m_cnt, m_out;
    bit m_flag, m_valid, m_ovr, m_sat;

    function automatic int reduce_m(input int s, input int nb, output bit c);
        int hi;
        int lo;
        int r;
        hi = (1 << (nb - 1)) - 1;
        lo = -(1 << (nb - 1));
        c  = 1'b0;
`ifdef MULT_DOT_ACCUM_SATURATE_EN
        if (s > hi) begin
            r = hi;
            c = 1'b1;
        end else if (s < lo) begin
            r = lo;
            c = 1'b1;
        end else begin
            r = s;
        end
`else
        r = s & ((1 << nb) - 1);
        if (r > hi) r = r - (1 << nb);
`endif
        return r;
    endfunction

    task automatic model_reset();
        m_acc = 0; m_cnt = 0; m_out = 0;
        m_flag = 0; m_valid = 0; m_ovr = 0; m_sat = 0;
        exp_q.delete();
    endtask

    // One clock of DUT A with the model advanced in step and every output
    // compared afterwards.
    task automatic step_a(input bit d, input int v, input bit clr, input bit rdy);
        bit   c;
        int   r;
        bit   old_valid;
        bit   pushed;
        res_t e;
        mult_a = 4'(v); done_a = d; clear_a = clr; ready_a = rdy;
        pushed = 1'b0;
        old_valid = m_valid;
        if (clr) begin
            m_acc = 0; m_cnt = 0; m_flag = 0; m_valid = 0; m_ovr = 0;
        end else begin
            if (m_valid && rdy) m_valid = 0;
            if (d) begin
                r = reduce_m(m_acc + v, 8, c);
                if (m_cnt < 3) begin
                    m_acc = r; m_cnt++; m_flag = m_flag | c;
                end else begin
                    if (old_valid && !rdy) m_ovr = 1;
                    m_valid = 1; m_out = r; m_sat = m_flag | c;
                    exp_q.push_back('{r, m_flag | c});
                    pushed = 1'b1;
                    m_acc = 0; m_cnt = 0; m_flag = 0;
                end
            end
        end
        @(posedge clk); #1;
        done_a = 1'b0; clear_a = 1'b0;
        checks++;
        if (valid_a !== m_valid) begin
            errors++; $display("FAIL valid: got %b expected %b", valid_a, m_valid);
        end
        checks++;
        if (ovr_a !== m_ovr) begin
            errors++; $display("FAIL overrun: got %b expected %b", ovr_a, m_ovr);
        end
        checks++;
        if (busy_a !== (m_cnt != 0)) begin
            errors++; $display("FAIL busy: got %b expected %b", busy_a, (m_cnt != 0));
        end
        if (pushed) begin
            e = exp_q.pop_front();
            checks++;
            if (acc_a !== 8'(e.acc)) begin
                errors++; $display("FAIL result: got %0d expected %0d", acc_a, e.acc);
            end
            checks++;
            if (sat_a !== e.sat) begin
                errors++; $display("FAIL result_sat: got %b expected %b", sat_a, e.sat);
            end
        end else begin
            checks++;
            if (acc_a !== 8'(m_out)) begin
                errors++; $display("FAIL acc_hold: got %0d expected %0d", acc_a, m_out);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        done_a = 0; clear_a = 0; ready_a = 0; mult_a = '0;
        done_b = 0; clear_b = 0; ready_b = 1; mult_b = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        checks++;
        if ({acc_a, valid_a, sat_a, ovr_a, busy_a} !== 12'h000) begin
            errors++;
            $display("FAIL reset_a: got acc=%0d v=%b s=%b o=%b b=%b expected all 0",
                     acc_a, valid_a, sat_a, ovr_a, busy_a);
        end
        checks++;
        if ({acc_b, valid_b, sat_b, ovr_b, busy_b} !== 10'h000) begin
            errors++;
            $display("FAIL reset_b: got acc=%0d v=%b s=%b o=%b b=%b expected all 0",
                     acc_b, valid_b, sat_b, ovr_b, busy_b);
        end
    endtask

    task automatic test_basic();
        step_a(1, 3, 0, 1);
        checks++;
        if (busy_a !== 1'b1) begin
            errors++; $display("FAIL basic_busy: got %b expected 1", busy_a);
        end
        step_a(1, -2, 0, 1);
        step_a(1, 5, 0, 1);
        step_a(1, 1, 0, 1);
        checks++;
        if (acc_a !== 8'sd7 || valid_a !== 1'b1) begin
            errors++; $display("FAIL basic_sum: got %0d v=%b expected 7 v=1", acc_a, valid_a);
        end
        step_a(0, 0, 0, 1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) step_a(1, -8, 0, 1);
        checks++;
        if (acc_a !== -8'sd32 || sat_a !== 1'b0) begin
            errors++; $display("FAIL b2b_neg: got %0d s=%b expected -32 s=0", acc_a, sat_a);
        end
        for (int i = 0; i < 4; i++) step_a(1, 7, 0, 1);
        checks++;
        if (acc_a !== 8'sd28) begin
            errors++; $display("FAIL b2b_pos: got %0d expected 28", acc_a);
        end
        step_a(0, 0, 0, 1);
    endtask

    task automatic test_overrun();
        step_a(0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step_a(1, 1, 0, 0);
        step_a(1, -1, 0, 0);
        step_a(1, -2, 0, 0);
        step_a(1, -3, 0, 0);
        step_a(1, 0, 0, 0);
        checks++;
        if (acc_a !== -8'sd6 || valid_a !== 1'b1 || ovr_a !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: got %0d v=%b o=%b expected -6 v=1 o=1", acc_a, valid_a, ovr_a);
        end
        step_a(0, 0, 0, 1);
        step_a(0, 0, 0, 1);
        checks++;
        if (ovr_a !== 1'b1) begin
            errors++; $display("FAIL overrun_sticky: got %b expected 1", ovr_a);
        end
        step_a(0, 0, 1, 1);
        checks++;
        if (ovr_a !== 1'b0) begin
            errors++; $display("FAIL overrun_clear: got %b expected 0", ovr_a);
        end
    endtask

    task automatic test_consume_coincide();
        for (int i = 0; i < 4; i++) step_a(1, 1, 0, 0);
        for (int i = 0; i < 3; i++) step_a(1, 2, 0, 0);
        step_a(1, 2, 0, 1);
        checks++;
        if (valid_a !== 1'b1 || acc_a !== 8'sd8 || ovr_a !== 1'b0) begin
            errors++;
            $display("FAIL coincide: got %0d v=%b o=%b expected 8 v=1 o=0", acc_a, valid_a, ovr_a);
        end
        step_a(0, 0, 0, 1);
    endtask

    task automatic test_clear();
        step_a(1, 3, 0, 1);
        step_a(1, 3, 0, 1);
        step_a(1, 3, 1, 1);
        checks++;
        if (busy_a !== 1'b0) begin
            errors++; $display("FAIL clear_busy: got %b expected 0", busy_a);
        end
        for (int i = 0; i < 4; i++) step_a(1, 1, 0, 1);
        checks++;
        if (acc_a !== 8'sd4) begin
            errors++; $display("FAIL clear_sum: got %0d expected 4", acc_a);
        end
        step_a(1, 5, 0, 1);
        step_a(1, 5, 0, 1);
        test_reset();
    endtask

    task automatic test_wide();
        logic signed [5:0] exp_acc;
        logic              exp_sat;
`ifdef MULT_DOT_ACCUM_SATURATE_EN
        exp_acc = 6'sd31;
        exp_sat = 1'b1;
`else
        exp_acc = -6'sd8;
        exp_sat = 1'b0;
`endif
        ready_b = 1'b1;
        for (int i = 0; i < 8; i++) begin
            mult_b = 4'sd7; done_b = 1'b1;
            @(posedge clk); #1;
            done_b = 1'b0;
        end
        checks++;
        if (acc_b !== exp_acc || valid_b !== 1'b1) begin
            errors++; $display("FAIL wide_acc: got %0d v=%b expected %0d v=1", acc_b, valid_b, exp_acc);
        end
        checks++;
        if (sat_b !== exp_sat) begin
            errors++; $display("FAIL wide_sat: got %b expected %b", sat_b, exp_sat);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_overrun();
        test_consume_coincide();
        test_clear();
        test_wide();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_dot_accum.md
Name: mult_dot_accum

Overview:
- Downstream stage of the sequential signed multiplier.
- Captures each product on the multiplier's one-cycle done strobe and sign-extends it into a wider accumulator.
- After N_TAPS products, presents the dot-product result on a valid/ready output port.
- Feeds the filter/result register bank; flags results that are lost because the consumer stalled.

Parameters:
- NB_DATA, 4: width of signed product input (matches multiplier output width).
- NB_ACC, 8: width of signed accumulator and result; must be >= NB_DATA.
- N_TAPS, 4: products per dot-product block; >= 2.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_mult  in  NB_DATA  signed product from multiplier.
- i_mult_done  in  1  one-cycle strobe; i_mult valid this cycle.
- i_clear  in  1  synchronous block abort/flush.
- i_ready  in  1  consumer accepts o_acc this cycle.
- o_acc  out  NB_ACC  signed dot-product result.
- o_valid  out  1  o_acc holds an unconsumed result.
- o_sat  out  1  saturation occurred in the block now on o_acc.
- o_overrun  out  1  sticky: an unconsumed result was overwritten.
- o_busy  out  1  partial block in progress (tap count != 0).

Behaviour:
- Reset (i_rst, sync, active-high, highest priority): acc=0, tap count=0, o_acc=0, o_valid=0, o_sat=0, o_overrun=0, o_busy=0.
- Arithmetic:
  - ext = i_mult sign-extended to NB_ACC.
  - sum computed at NB_ACC+1 bits, then reduced to NB_ACC per the SATURATE_EN rules.
- Input FSM, two states:
  - ACC_IDLE: count=0.
  - ACC_RUN: 0<count<N_TAPS.
- Strobe handling:
  - Strobe with count<N_TAPS-1: acc<=sum, count++, state->ACC_RUN; block saturation flag ORs in this step's clamp.
  - Strobe with count==N_TAPS-1: o_acc<=sum, o_sat<=accumulated flag OR this step's clamp, o_valid<=1, acc<=0, count<=0, flag<=0, state->ACC_IDLE.
  - Latency: result visible one cycle after the final strobe.
- Output side:
  - o_valid&&i_ready consumes: o_valid<=0 next cycle unless a new result loads the same cycle; in that case o_valid stays 1 and no overrun.
  - Final strobe while o_valid=1 and i_ready=0: o_acc/o_sat overwritten, o_overrun<=1.
  - o_overrun stays set until i_clear or reset.
- i_clear: acc<=0, count<=0, flag<=0, o_valid<=0, o_overrun<=0, state->ACC_IDLE.
  - Takes priority over a coincident i_mult_done; that product is dropped.
  - o_acc keeps its old value.
- No strobe: all state held; o_acc stable while o_valid=1.
- o_busy = (count!=0), registered state, combinational decode.
- i_mult_done on consecutive cycles is legal; every strobe is accumulated.

Optional Feature:
- Macro: MULT_DOT_ACCUM_SATURATE_EN.
- Defined:
  - If sum > 2^(NB_ACC-1)-1, clamp to that value; if sum < -2^(NB_ACC-1), clamp to that value.
  - Each clamp sets the block saturation flag, reported on o_sat with the result.
  - Accumulation continues from the clamped value.
- Undefined:
  - Two's-complement wrap modulo 2^NB_ACC (low NB_ACC bits of sum).
  - o_sat tied to 0.

Test Plan:
- Defaults, i_ready=1: strobes with products 3,-2,5,1 -> o_valid=1 with o_acc=7 one cycle after the 4th strobe; o_valid=0 the next cycle; o_busy high after the 1st strobe until the 4th.
- Back-to-back strobes -8 ×4 (every cycle) -> o_acc=-32, o_sat=0; next block 7,7,7,7 -> o_acc=28.
- i_ready=0, two full blocks (sums 4 then -6) -> after the 2nd, o_acc=-6, o_valid=1, o_overrun=1; o_overrun stays 1 after i_ready=1 until i_clear.
- Final strobe coincides with an i_ready=1 consume of the prior result -> o_valid stays 1, new value on o_acc, o_overrun=0.
- i_clear after 2 strobes (3,3), coincident with a 3rd strobe; then 4 strobes of 1 -> o_acc=4 (the cleared partial and the dropped product are absent); i_rst mid-block -> all outputs 0.
- NB_ACC=6, N_TAPS=8, eight products of 7 -> with macro o_acc=31, o_sat=1; without macro o_acc=-8, o_sat=0.
